// File: rtl/rx_buffer_reader.sv
// Read-side sequencer for the RX sample buffer BRAM (port B): streams a circular
// address range out over valid/ready, absorbing BRAM latency in a 2-entry skid FIFO.
module rx_buffer_reader #(
    parameter int ADDR_MSB = 12,
    parameter int BRAM_LAT = 1
) (
    input  logic                cpu_clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_MSB:0]   start_addr,
    input  logic [ADDR_MSB+1:0] nwords,
    input  logic                abort,
    output logic [ADDR_MSB:0]   rd_addr,
    input  logic [15:0]         rd_data,
    output logic [15:0]         tdata,
    output logic                tvalid,
    input  logic                tready,
    output logic                tlast,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    localparam int AW = ADDR_MSB + 1;
    localparam int CW = ADDR_MSB + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    typedef logic [BRAM_LAT-1:0] pipe_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [CW-1:0]   issue_left;
    logic [CW-1:0]   nwords_q;
    logic [CW-1:0]   delivered;
    pipe_t           pipe;
    logic [15:0]     fifo_mem [2];
    logic            wr_ptr;
    logic            rd_ptr;
    logic [1:0]      fifo_count;
    logic [1:0]      inflight;
    logic [2:0]      slots;
    logic            accept;
    logic            issue;
    logic            push;
    logic            pop;
    logic            last_beat;

    // Stream handshake: a word transfers on any edge where tvalid & tready are both
    // high; while tvalid is high and tready low, tdata/tlast/tvalid do not change.
    assign tvalid    = (fifo_count != 2'd0);
    assign tdata     = tvalid ? fifo_mem[rd_ptr] : 16'h0000;
    assign tlast     = tvalid && ((delivered + CW'(1)) == nwords_q);
    assign pop       = tvalid && tready;
    assign last_beat = pop && tlast;
    assign push      = pipe[BRAM_LAT-1];
    assign accept    = (state == S_IDLE) && start && !abort;
    assign state_dbg = state;

    always_comb begin
        inflight = 2'd0;
        for (int i = 0; i < BRAM_LAT; i++) begin
            inflight = inflight + {1'b0, pipe[i]};
        end
    end

    // Occupancy projected past this edge's pop, so a steady tready gives one word per clock.
    assign slots = {1'b0, fifo_count} + {1'b0, inflight} - {2'b00, pop};

    // State register
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (nwords != '0)) begin
                    state_nxt = S_STREAM;
                end
            end
            S_STREAM: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (issue && (issue_left == CW'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort || last_beat) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state != S_IDLE);
        issue = (state == S_STREAM) && !abort && (issue_left != '0) && (slots < 3'd2);
    end

    // Datapath: address generation, read pipeline, skid FIFO, beat counting.
    // A read counts as issued on the edge that loads rd_addr; its data is sampled
    // from rd_data BRAM_LAT edges later.
    always_ff @(posedge cpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr     <= '0;
            addr_nxt    <= '0;
            issue_left  <= '0;
            nwords_q    <= '0;
            delivered   <= '0;
            pipe        <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_count  <= 2'd0;
            done        <= 1'b0;
            fifo_mem[0] <= 16'h0000;
            fifo_mem[1] <= 16'h0000;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                pipe       <= '0;
                wr_ptr     <= 1'b0;
                rd_ptr     <= 1'b0;
                fifo_count <= 2'd0;
                delivered  <= '0;
                issue_left <= '0;
            end else begin
                if (accept) begin
                    addr_nxt   <= start_addr;
                    issue_left <= nwords;
                    nwords_q   <= nwords;
                    delivered  <= '0;
                    done       <= (nwords == '0);
                end
                if (issue) begin
                    rd_addr    <= addr_nxt;
                    addr_nxt   <= addr_nxt + AW'(1);
                    issue_left <= issue_left - CW'(1);
                end
                pipe <= (pipe << 1) | pipe_t'(issue);
                if (push) begin
                    fifo_mem[wr_ptr] <= rd_data;
                    wr_ptr           <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr    <= ~rd_ptr;
                    delivered <= delivered + CW'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + 2'd1;
                    2'b01:   fifo_count <= fifo_count - 2'd1;
                    default: fifo_count <= fifo_count;
                endcase
                if (last_beat) begin
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rx_buffer_reader.sv
// Randomized bench for rx_buffer_reader: a BRAM model, a cycle monitor with an
// expected-word queue, and directed scenarios for wrap, abort, zero-length and reset.
module tb_rx_buffer_reader;

    localparam int ADDR_MSB = 12;
    localparam int AW       = ADDR_MSB + 1;
    localparam int CW       = ADDR_MSB + 2;
    localparam int DEPTH    = 1 << AW;

    logic          cpu_clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] nwords;
    logic          abort;
    logic [AW-1:0] rd_addr;
    logic [15:0]   rd_data;
    logic [15:0]   tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    logic [15:0]   mem [DEPTH];
    logic [15:0]   exp_q [$];

    int n_cmp;
    int n_bad;
    int beats;
    int rdy_mode;
    bit mon_en;
    bit busy_m;
    bit done_m;
    bit prev_stall;
    logic [15:0] prev_data;
    logic        prev_last;

    rx_buffer_reader #(.ADDR_MSB(ADDR_MSB), .BRAM_LAT(1)) dut (
        .cpu_clk    (cpu_clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .nwords     (nwords),
        .abort      (abort),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .tdata      (tdata),
        .tvalid     (tvalid),
        .tready     (tready),
        .tlast      (tlast),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // Port B with one clock of latency measured from the edge that loads rd_addr.
    assign rd_data = mem[rd_addr];

    // clock / reset
    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // tready driver
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge cpu_clk);
            #1;
            tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // Monitor / reference model: checks current outputs, then predicts the next edge.
    always @(negedge cpu_clk) begin
        if (mon_en) begin
            logic [15:0] e;
            bit hs_last;
            hs_last = 1'b0;
            check("busy", 32'(busy), 32'(busy_m));
            check("done", 32'(done), 32'(done_m));
            if (!busy_m) check("idle_tvalid", 32'(tvalid), 32'd0);
            if (prev_stall) begin
                check("hold_valid", 32'(tvalid), 32'd1);
                check("hold_data", 32'(tdata), 32'(prev_data));
                check("hold_last", 32'(tlast), 32'(prev_last));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    beats++;
                    check("tdata", 32'(tdata), 32'(e));
                    check("tlast", 32'(tlast), 32'(exp_q.size() == 0));
                    hs_last = (exp_q.size() == 0);
                end
            end
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
            done_m = 1'b0;
            if (abort && busy_m) begin
                busy_m = 1'b0;
                exp_q.delete();
            end else if (!busy_m && start && !abort) begin
                if (nwords == '0) begin
                    done_m = 1'b1;
                end else begin
                    busy_m = 1'b1;
                    beats  = 0;
                    for (int i = 0; i < int'(nwords); i++) begin
                        exp_q.push_back(mem[(int'(start_addr) + i) % DEPTH]);
                    end
                end
            end else if (hs_last) begin
                busy_m = 1'b0;
                done_m = 1'b1;
            end
        end
    end

    // driver tasks
    task automatic send_start(input int addr, input int n);
        @(posedge cpu_clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(addr);
        nwords     = CW'(n);
        @(posedge cpu_clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge cpu_clk);
        #1;
        abort = 1'b1;
        @(posedge cpu_clk);
        #1;
        abort = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int k;
        k = 0;
        while ((busy_m || busy || done) && k < limit) begin
            @(posedge cpu_clk);
            k++;
        end
        repeat (2) @(posedge cpu_clk);
        if (k >= limit) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Start issued ahead of edge 0; tvalid expected after edge 2, done after edge n+2.
    task automatic latency_run(input int addr, input int n);
        int first_tv;
        int done_k;
        first_tv = -1;
        done_k   = -1;
        @(posedge cpu_clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(addr);
        nwords     = CW'(n);
        @(posedge cpu_clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= n + 20; k++) begin
            @(posedge cpu_clk);
            #1;
            if (k == 1) check("lat_rd_addr", 32'(rd_addr), 32'(addr));
            if (tvalid && first_tv < 0) first_tv = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
        check("lat_first_tvalid", 32'(first_tv), 32'd2);
        check("lat_done_edge", 32'(done_k), 32'(n + 2));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_tvalid"}, 32'(tvalid), 32'd0);
        check({tag, "_tdata"}, 32'(tdata), 32'd0);
        check({tag, "_tlast"}, 32'(tlast), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        check({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; beats = 0; rdy_mode = 0;
        mon_en = 1'b0; busy_m = 1'b0; done_m = 1'b0; prev_stall = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        start = 1'b0; start_addr = '0; nwords = '0; abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset");
        repeat (3) @(posedge cpu_clk);
        #3 rst_n = 1'b1;
        @(posedge cpu_clk);
        #1;
        check_outputs_zero("post_reset");
        mon_en = 1'b1;

        // basic transfer, with latency
        latency_run(32'h010, 4);
        wait_idle(100);

        // wrap at the top of the buffer
        latency_run(32'h1FFE, 4);
        wait_idle(100);

        // backpressure
        rdy_mode = 1;
        send_start(32'h123, 8);
        wait_idle(200);

        for (int t = 0; t < 20; t++) begin
            send_start($urandom_range(0, DEPTH - 1), $urandom_range(1, 40));
            wait_idle(1000);
        end

        // abort on the third beat, then a fresh short transfer
        rdy_mode = 0;
        send_start(32'h0400, 16);
        for (int k = 0; k < 100 && beats < 2; k++) @(negedge cpu_clk);
        check("abort_beats_reached", 32'(beats), 32'd2);
        pulse_abort();
        check("abort_tvalid", 32'(tvalid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        wait_idle(50);
        send_start(32'h0800, 2);
        wait_idle(50);

        // abort under random backpressure
        rdy_mode = 1;
        send_start($urandom_range(0, DEPTH - 1), 20);
        repeat ($urandom_range(2, 15)) @(posedge cpu_clk);
        pulse_abort();
        wait_idle(50);

        // zero-length start, idle abort, start while busy
        rdy_mode = 0;
        send_start(32'h0055, 0);
        wait_idle(20);
        pulse_abort();
        wait_idle(20);
        rdy_mode = 1;
        send_start(32'h0300, 10);
        repeat (3) @(posedge cpu_clk);
        send_start(32'h0900, 5);
        wait_idle(200);

        // whole buffer in one transfer
        rdy_mode = 0;
        send_start(32'h0777, DEPTH);
        wait_idle(DEPTH + 100);

        // asynchronous reset mid-transfer, off the clock edge
        rdy_mode = 1;
        send_start(32'h0A00, 30);
        repeat (8) @(posedge cpu_clk);
        #3;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        busy_m = 1'b0; done_m = 1'b0; prev_stall = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge cpu_clk);
        #3 rst_n = 1'b1;
        @(negedge cpu_clk);
        mon_en = 1'b1;
        send_start(32'h0B00, 6);
        wait_idle(200);

        check("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
